target_response_checker: RTL and testbench

//  Player-side end of the target/"correct" loop. Latches the target index from the random

---
 rtl/target_response_checker_pkg.sv | 28 ++
 rtl/target_response_checker_if.sv | 36 +++
 rtl/target_response_checker_key_edge_detect.sv | 36 +++
 rtl/target_response_checker.sv | 175 +++++++++++++++++
 tb/tb_target_response_checker.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/target_response_checker_pkg.sv
// -----------------------------------------------------------------------------
// target_response_checker_pkg
// Shared types and defaults for the target/response checker slice.
//   NUM_KEYS_DEF / TGT_W_DEF : default key count and target index width
//   state_t                  : game FSM states
//   result_t                 : outcome of one WAIT cycle (NONE when undecided)
// -----------------------------------------------------------------------------
package target_response_checker_pkg;

    localparam int NUM_KEYS_DEF = 4;
    localparam int TGT_W_DEF    = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARM,
        ST_WAIT,
        ST_FB,
        ST_OVER
    } state_t;

    typedef enum logic [1:0] {
        RES_NONE,
        RES_HIT,
        RES_MISS,
        RES_TOUT
    } result_t;

endpackage

// File: rtl/target_response_checker_if.sv
// -----------------------------------------------------------------------------
// target_response_checker_if
// Bundles the player/generator side signals of the checker.
//   master : drives tick, start, target, keys; observes the game outputs
//   slave  : the checker itself
// -----------------------------------------------------------------------------
interface target_response_checker_if #(
    parameter int NUM_KEYS = 4,
    parameter int TGT_W    = 2,
    parameter int SCORE_W  = 8
);

    logic                tick;
    logic                start;
    logic [TGT_W-1:0]    target;
    logic [NUM_KEYS-1:0] keys;
    logic                correct;
    logic                wrong;
    logic                timeout;
    logic [TGT_W-1:0]    target_q;
    logic                show_target;
    logic [SCORE_W-1:0]  score;
    logic [1:0]          lives;
    logic                game_over;

    modport master (
        output tick, start, target, keys,
        input  correct, wrong, timeout, target_q, show_target, score, lives, game_over
    );

    modport slave (
        input  tick, start, target, keys,
        output correct, wrong, timeout, target_q, show_target, score, lives, game_over
    );

endinterface

// File: rtl/target_response_checker_key_edge_detect.sv
// -----------------------------------------------------------------------------
// key_edge_detect
// Registers the synchronised key levels and reports rising edges.
//   clk, reset : system clock, synchronous active-high reset
//   keys       : key levels, active-high
//   edges      : keys that went 0->1 this cycle
//   onehot     : exactly one bit of edges is set
// -----------------------------------------------------------------------------
module key_edge_detect #(
    parameter int NUM_KEYS = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_KEYS-1:0] keys,
    output logic [NUM_KEYS-1:0] edges,
    output logic                onehot
);

    logic [NUM_KEYS-1:0] keys_d;

    // The delayed copy updates in every game state, so a key held through
    // feedback never looks like a fresh press later on.
    always_ff @(posedge clk) begin
        if (reset) begin
            keys_d <= '0;
        end else begin
            keys_d <= keys;
        end
    end

    assign edges = keys & ~keys_d;

    // x & (x-1) clears the lowest set bit; zero afterwards means a single bit.
    assign onehot = (edges != '0) && ((edges & (edges - NUM_KEYS'(1))) == '0);

endmodule

// File: rtl/target_response_checker.sv
// -----------------------------------------------------------------------------
// target_response_checker
// Player-side end of the target/"correct" loop: latches the generator's target,
// waits for a clean key press, judges it, and keeps score, lives and a round
// deadline that shrinks after every hit.
//   clk, reset : system clock, synchronous active-high reset
//   bus.tick   : 1 kHz enable that paces the round and feedback timers
//   bus.start  : starts a game from IDLE or OVER
//   bus.target, bus.keys           : generator index and player keys
//   bus.correct/wrong/timeout      : one-cycle result pulses
//   bus.target_q, bus.show_target  : target shown to the player during WAIT
//   bus.score, bus.lives, bus.game_over : game status
// -----------------------------------------------------------------------------
module target_response_checker
    import target_response_checker_pkg::*;
#(
    parameter int NUM_KEYS    = NUM_KEYS_DEF,
    parameter int TGT_W       = TGT_W_DEF,
    parameter int SCORE_W     = 8,
    parameter int MAX_LIVES   = 3,
    parameter int ROUND_TICKS = 2000,
    parameter int MIN_TICKS   = 500,
    parameter int STEP_TICKS  = 50,
    parameter int FB_TICKS    = 300
) (
    input logic clk,
    input logic reset,
    target_response_checker_if.slave bus
);

    localparam int TIMER_W = $clog2(ROUND_TICKS + 1);

    state_t               state;
    result_t              result;
    logic [TIMER_W-1:0]   timer;
    logic [TIMER_W-1:0]   deadline;
    logic [TIMER_W-1:0]   deadline_next;
    int                   deadline_reduced;
    logic [TGT_W-1:0]     target_q;
    logic [SCORE_W-1:0]   score;
    logic [1:0]           lives;
    logic                 correct_q;
    logic                 wrong_q;
    logic                 timeout_q;
    logic                 show_q;
    logic                 over_q;
    logic [NUM_KEYS-1:0]  edges;
    logic                 onehot;

    key_edge_detect #(
        .NUM_KEYS(NUM_KEYS)
    ) u_edge (
        .clk    (clk),
        .reset  (reset),
        .keys   (bus.keys),
        .edges  (edges),
        .onehot (onehot)
    );

    // Judge the current WAIT cycle. A key edge always takes priority over the
    // deadline running out on the same cycle; the timeout fires on the tick
    // that would take the timer from 1 to 0.
    always_comb begin
        result = RES_NONE;
        if (state == ST_WAIT) begin
            if (edges != '0) begin
                result = (onehot && edges[target_q]) ? RES_HIT : RES_MISS;
            end else if (bus.tick && (timer <= TIMER_W'(1))) begin
                result = RES_TOUT;
            end
        end
    end

    // Shrink the deadline in a signed full-width integer so the floor clamp
    // works even if a step would go below zero.
    always_comb begin
        deadline_reduced = int'(deadline) - STEP_TICKS;
        if (deadline_reduced < MIN_TICKS) begin
            deadline_next = TIMER_W'(MIN_TICKS);
        end else begin
            deadline_next = TIMER_W'(deadline_reduced);
        end
    end

    // Game FSM. All outputs are registered here; result pulses default low so
    // each one lasts exactly the cycle after the decision.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            timer     <= '0;
            deadline  <= TIMER_W'(ROUND_TICKS);
            target_q  <= '0;
            score     <= '0;
            lives     <= 2'(MAX_LIVES);
            correct_q <= 1'b0;
            wrong_q   <= 1'b0;
            timeout_q <= 1'b0;
            show_q    <= 1'b0;
            over_q    <= 1'b0;
        end else begin
            correct_q <= 1'b0;
            wrong_q   <= 1'b0;
            timeout_q <= 1'b0;
            case (state)
                ST_IDLE, ST_OVER: begin
                    if (bus.start) begin
                        score    <= '0;
                        lives    <= 2'(MAX_LIVES);
                        deadline <= TIMER_W'(ROUND_TICKS);
                        over_q   <= 1'b0;
                        state    <= ST_ARM;
                    end
                end
                ST_ARM: begin
                    if (bus.keys == '0) begin
                        target_q <= bus.target;
                        timer    <= deadline;
                        show_q   <= 1'b1;
                        state    <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    case (result)
                        RES_HIT: begin
                            correct_q <= 1'b1;
                            if (score != '1) begin
                                score <= score + SCORE_W'(1);
                            end
                            deadline <= deadline_next;
                            timer    <= TIMER_W'(FB_TICKS);
                            show_q   <= 1'b0;
                            state    <= ST_FB;
                        end
                        RES_MISS, RES_TOUT: begin
                            wrong_q   <= (result == RES_MISS);
                            timeout_q <= (result == RES_TOUT);
                            lives     <= lives - 2'd1;
                            show_q    <= 1'b0;
                            if (lives <= 2'd1) begin
                                over_q <= 1'b1;
                                state  <= ST_OVER;
                            end else begin
                                timer <= TIMER_W'(FB_TICKS);
                                state <= ST_FB;
                            end
                        end
                        default: begin
                            if (bus.tick) begin
                                timer <= timer - TIMER_W'(1);
                            end
                        end
                    endcase
                end
                ST_FB: begin
                    if (timer == '0) begin
                        state <= ST_ARM;
                    end else if (bus.tick) begin
                        timer <= timer - TIMER_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.correct     = correct_q;
    assign bus.wrong       = wrong_q;
    assign bus.timeout     = timeout_q;
    assign bus.target_q    = target_q;
    assign bus.show_target = show_q;
    assign bus.score       = score;
    assign bus.lives       = lives;
    assign bus.game_over   = over_q;

endmodule

// File: tb/tb_target_response_checker.sv
// -----------------------------------------------------------------------------
// tb_target_response_checker
// Directed bench for target_response_checker. busA/dutA uses the default
// parameters; busB/dutB shortens the feedback hold so long runs of hits
// (deadline floor, score saturation) stay quick. tick is held high so one
// clock equals one timebase tick.
// -----------------------------------------------------------------------------
module tb_target_response_checker;

    logic clk = 1'b0;
    logic resetA;
    logic resetB;
    bit   useB = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   n;

    always #5 clk = ~clk;

    target_response_checker_if #(.NUM_KEYS(4), .TGT_W(2), .SCORE_W(8)) busA ();
    target_response_checker_if #(.NUM_KEYS(4), .TGT_W(2), .SCORE_W(8)) busB ();

    target_response_checker dutA (
        .clk   (clk),
        .reset (resetA),
        .bus   (busA.slave)
    );

    target_response_checker #(.FB_TICKS(2)) dutB (
        .clk   (clk),
        .reset (resetB),
        .bus   (busB.slave)
    );

    // Observation mux so the same tasks serve both instances
    logic       selShow, selCorrect, selWrong, selTimeout, selOver;
    logic [7:0] selScore;
    logic [1:0] selLives, selTargetQ;

    assign selShow    = useB ? busB.show_target : busA.show_target;
    assign selCorrect = useB ? busB.correct     : busA.correct;
    assign selWrong   = useB ? busB.wrong       : busA.wrong;
    assign selTimeout = useB ? busB.timeout     : busA.timeout;
    assign selOver    = useB ? busB.game_over   : busA.game_over;
    assign selScore   = useB ? busB.score       : busA.score;
    assign selLives   = useB ? busB.lives       : busA.lives;
    assign selTargetQ = useB ? busB.target_q    : busA.target_q;

    typedef struct {
        logic [1:0] target;
        logic [3:0] keys;
        logic [1:0] nextTarget;
        int         expTicks;
        bit         expCorrect;
        bit         expWrong;
        bit         expTimeout;
        int         expScore;
        int         expLives;
    } vec_t;

    vec_t vecA [3];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic step(input int cycles);
        repeat (cycles) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic [3:0] keys);
        if (useB) busB.keys = keys;
        else      busA.keys = keys;
    endtask

    task automatic setTarget(input logic [1:0] t);
        if (useB) busB.target = t;
        else      busA.target = t;
    endtask

    task automatic pulseStart();
        if (useB) busB.start = 1'b1;
        else      busA.start = 1'b1;
        step(1);
        if (useB) busB.start = 1'b0;
        else      busA.start = 1'b0;
    endtask

    task automatic waitShow(input int limit, output int cycles);
        cycles = 0;
        while (!selShow && cycles < limit) begin
            step(1);
            cycles++;
        end
        checkOutput("wait_show_target", selShow, 1);
    endtask

    task automatic waitTimeout(input int limit, output int cycles);
        cycles = 0;
        while (!selTimeout && cycles < limit) begin
            step(1);
            cycles++;
        end
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_correct"},  selCorrect, 0);
        checkOutput({tag, "_wrong"},    selWrong, 0);
        checkOutput({tag, "_timeout"},  selTimeout, 0);
        checkOutput({tag, "_show"},     selShow, 0);
        checkOutput({tag, "_over"},     selOver, 0);
        checkOutput({tag, "_score"},    selScore, 0);
        checkOutput({tag, "_lives"},    selLives, 3);
        checkOutput({tag, "_target_q"}, selTargetQ, 0);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete, got running, expected finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecA[0] = '{2'd2, 4'b0100, 2'd3, 0,    1'b1, 1'b0, 1'b0, 1, 3};
        vecA[1] = '{2'd3, 4'b0000, 2'd1, 1950, 1'b0, 1'b0, 1'b1, 1, 2};
        vecA[2] = '{2'd1, 4'b0001, 2'd3, 0,    1'b0, 1'b1, 1'b0, 1, 1};

        busA.tick = 1'b1; busA.start = 1'b0; busA.target = 2'd0; busA.keys = 4'd0;
        busB.tick = 1'b1; busB.start = 1'b0; busB.target = 2'd0; busB.keys = 4'd0;
        resetA = 1'b1;
        resetB = 1'b1;
        step(2);

        // ---------------- instance A: default parameters ----------------
        useB = 1'b0;
        checkResetState("resetA");
        resetA = 1'b0;
        resetB = 1'b0;

        setTarget(vecA[0].target);
        pulseStart();
        checkOutput("start_lives", selLives, 3);
        checkOutput("start_score", selScore, 0);

        for (int i = 0; i < 3; i++) begin
            waitShow(2500, n);
            checkOutput("vec_target_q", selTargetQ, vecA[i].target);
            if (vecA[i].keys != 4'd0) begin
                applyStimulus(vecA[i].keys);
                step(1);
            end else begin
                waitTimeout(2500, n);
                checkOutput("vec_timeout_ticks", n, vecA[i].expTicks);
            end
            setTarget(vecA[i].nextTarget);
            checkOutput("vec_correct", selCorrect, vecA[i].expCorrect);
            checkOutput("vec_wrong",   selWrong,   vecA[i].expWrong);
            checkOutput("vec_timeout", selTimeout, vecA[i].expTimeout);
            checkOutput("vec_score",   selScore,   vecA[i].expScore);
            checkOutput("vec_lives",   selLives,   vecA[i].expLives);
            checkOutput("vec_show_fb", selShow, 0);
            checkOutput("vec_over",    selOver, 0);
            applyStimulus(4'd0);
            step(1);
            checkOutput("vec_pulse_one_cycle", {selCorrect, selWrong, selTimeout}, 0);
            n = 0;
            while (!selShow && n < 2500) begin
                step(1);
                n++;
            end
            checkOutput("vec_fb_cycles", n, 301);
        end

        // Hit while holding the key through feedback: ARM must wait for release
        checkOutput("hold_target_q", selTargetQ, 3);
        setTarget(2'd0);
        applyStimulus(4'b1000);
        step(1);
        checkOutput("hold_correct", selCorrect, 1);
        checkOutput("hold_score", selScore, 2);
        step(352);
        checkOutput("hold_stays_arm", selShow, 0);
        applyStimulus(4'd0);
        step(1);
        checkOutput("release_enters_wait", selShow, 1);
        checkOutput("release_no_result", {selCorrect, selWrong, selTimeout}, 0);
        checkOutput("release_target_q", selTargetQ, 0);

        // Simultaneous edges on the last life: miss, straight to OVER
        applyStimulus(4'b0101);
        step(1);
        checkOutput("multi_wrong", selWrong, 1);
        checkOutput("multi_lives", selLives, 0);
        checkOutput("multi_over", selOver, 1);
        applyStimulus(4'd0);
        step(400);
        checkOutput("over_no_fb", selShow, 0);
        checkOutput("over_holds", selOver, 1);
        checkOutput("over_score_hold", selScore, 2);

        // Restart from OVER, then start inside WAIT must be ignored
        setTarget(2'd1);
        pulseStart();
        checkOutput("restart_over", selOver, 0);
        checkOutput("restart_score", selScore, 0);
        checkOutput("restart_lives", selLives, 3);
        waitShow(5, n);
        pulseStart();
        checkOutput("start_ignored_wait", selShow, 1);

        // Reset arriving with a correct press: no pulse, reset values
        applyStimulus(4'b0010);
        resetA = 1'b1;
        step(1);
        checkResetState("reset_wait");
        resetA = 1'b0;
        applyStimulus(4'd0);
        step(1);
        checkOutput("after_reset_correct", selCorrect, 0);

        // ---------------- instance B: short feedback hold ----------------
        useB = 1'b1;
        setTarget(2'd0);
        pulseStart();
        waitShow(5, n);
        waitTimeout(2500, n);
        checkOutput("b_timeout_ticks", n, 2000);
        checkOutput("b_timeout_lives", selLives, 2);

        for (int i = 0; i < 260; i++) begin
            waitShow(20, n);
            checkOutput("b_target_q", selTargetQ, i % 4);
            applyStimulus(4'(1 << (i % 4)));
            step(1);
            setTarget(2'((i + 1) % 4));
            checkOutput("b_hit_correct", selCorrect, 1);
            checkOutput("b_hit_score", selScore, (i + 1 > 255) ? 255 : i + 1);
            applyStimulus(4'd0);
        end

        // Edge on the expiry tick wins; deadline sits at the 500 floor
        waitShow(20, n);
        step(499);
        checkOutput("b_late_no_timeout", selTimeout, 0);
        applyStimulus(4'b0001);
        step(1);
        checkOutput("b_edge_wins_correct", selCorrect, 1);
        checkOutput("b_edge_wins_timeout", selTimeout, 0);
        checkOutput("b_score_saturated", selScore, 255);
        applyStimulus(4'd0);
        waitShow(20, n);
        waitTimeout(2500, n);
        checkOutput("b_clamped_deadline", n, 500);
        checkOutput("b_clamped_lives", selLives, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
